spike_frame_serializer: RTL
===========================

// Module: spike_frame_serializer
// PURPOSE
//  Downstream of the 3x2 SNN top: captures the 250-bit spike_out vector once per tick and serializes it into 32-bit words.
//  A valid/ready handshake carries the words to the CPU-side readout (bus slave / DMA).
//  A one-frame pending buffer absorbs one back-to-back capture while the previous frame drains; overflow is flagged, never silent.
// PARAMETERS
//  SPIKE_W   250  width of captured spike vector
//  WORD_W    32   output word width
//  CNT_W     16   width of frame counter (wraps)
// PORTS
//  clk           in   1                   snn clock; all logic on rising edge
//  reset         in   1                   asynchronous, active-high reset
//  spike_in      in   SPIKE_W             spike vector from SNN top
//  spike_valid   in   1                   1-cycle capture strobe (asserted with spike_en at end of tick)
//  word_data     out  WORD_W              current output word
//  word_valid    out  1                   word_data valid
//  word_ready    in   1                   consumer accepts when word_valid&word_ready
//  word_last     out  1                   high with final word of a frame
//  word_idx      out  $clog2(NWORDS)      index of current word in frame
//  frame_done    out  1                   1-cycle pulse after last word accepted
//  busy          out  1                   frame in flight or pending
//  overflow      out  1                   sticky; set when a capture is dropped
//  ovf_clear     in   1                   clears overflow (wins over same-cycle set? no: set wins)
//  frame_count   out  CNT_W               frames fully transmitted, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  NWORDS = ceil(SPIKE_W/WORD_W) = 8; word k = shadow[k*WORD_W +: WORD_W], bits >= SPIKE_W read as 0 (word 7 bits [31:26]=0).
//  Reset: all outputs 0, state IDLE, shadow/pending cleared, pending_full=0.
//  FSM IDLE: word_valid=0; spike_valid -> capture spike_in into shadow, idx=0, go SEND.
//  FSM SEND: word_valid=1; hold word_data/word_idx/word_last stable while !word_ready.
//   accept & idx<NWORDS-1 -> idx+1. accept & idx==NWORDS-1 -> frame_done=1, frame_count+1, then:
//    pending_full -> promote pending to shadow, idx=0, stay SEND (no bubble, word_valid stays 1), pending_full=0;
//    else spike_valid same cycle -> capture directly into shadow, idx=0, stay SEND;
//    else -> IDLE.
//  Latency: spike_valid in cycle N -> word_valid=1 with word 0 in cycle N+1.
//  spike_valid in SEND (not on last-accept): pending empty -> capture into pending; pending full -> drop, overflow=1.
//  spike_valid on last-accept with pending full: pending promoted, new vector into pending; no overflow.
//  overflow: set has priority over ovf_clear in same cycle; otherwise ovf_clear -> 0 next cycle.
//  busy = (state==SEND) | pending_full. word_last = word_valid & (idx==NWORDS-1).
//  Reset mid-frame: asynchronous; frame abandoned, no frame_done, frame_count -> 0.
// CONFIGURATION
//  SPIKE_FRAME_POPCOUNT_EN defined: extra output spike_count [$clog2(SPIKE_W+1)-1:0] = number of set bits in the frame.
//   Registered at capture, valid from word 0 through word_last, held until next frame. Pending buffer carries its own count.
//  Undefined: port absent, no popcount logic.
// STRUCTURE
//  spike_readout_pkg: NWORDS localparam function, IDX_W, state enum {IDLE,SEND}, word-select function with zero pad.
//  Sub-module spike_popcount (combinational tree, SPIKE_W in, count out) instantiated only under SPIKE_FRAME_POPCOUNT_EN.
// TESTING
//  1: spike_in=all-ones, strobe, word_ready=1 -> 8 words on consecutive cycles, words 0-6=FFFFFFFF, word7=03FFFFFF, frame_count=1.
//  2: word_ready toggled 1/0 -> word_data/idx stable while stalled; word_last only on idx 7; frame_done 1 pulse.
//  3: strobe A, then strobe B at word 3 of A -> B drained after A with no idle cycle; overflow=0; frame_count=2.
//  4: strobes A,B,C during A's drain -> C dropped, overflow=1 until ovf_clear; only A,B sent.
//  5: strobe on the exact cycle A's last word accepted, pending empty -> next frame's word 0 next cycle, no overflow.
//  6: reset asserted at word 4 -> word_valid=0 immediately, busy=0, frame_count=0; popcount (if enabled) of 0x...5 pattern = 125.

Source files
------------

// File: rtl/spike_readout_pkg.sv
// Shared types and sizing helpers for the spike frame readout path.
package spike_readout_pkg;

  function automatic int unsigned nwords(input int unsigned spike_w,
                                         input int unsigned word_w);
    return (spike_w + word_w - 1) / word_w;
  endfunction

  localparam int unsigned SPIKE_W_DEF = 250;
  localparam int unsigned WORD_W_DEF  = 32;
  localparam int unsigned NWORDS_DEF  = nwords(SPIKE_W_DEF, WORD_W_DEF);
  localparam int unsigned IDX_W_DEF   = $clog2(NWORDS_DEF);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/spike_popcount.sv
// Combinational population count of a spike vector.
module spike_popcount #(
  parameter  int unsigned SPIKE_W = 250,
  localparam int unsigned CNT_W   = $clog2(SPIKE_W + 1)
) (
  input  logic [SPIKE_W-1:0] bits,
  output logic [CNT_W-1:0]   count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < SPIKE_W; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/spike_frame_serializer.sv
// Captures a spike vector per tick and streams it out as WORD_W-bit words with a
// one-frame pending buffer. Optional per-frame popcount under SPIKE_FRAME_POPCOUNT_EN.
module spike_frame_serializer
  import spike_readout_pkg::*;
#(
  parameter  int unsigned SPIKE_W = 250,
  parameter  int unsigned WORD_W  = 32,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned NWORDS  = nwords(SPIKE_W, WORD_W),
  localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int unsigned FRAME_W = NWORDS * WORD_W,
  localparam int unsigned PC_W    = $clog2(SPIKE_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SPIKE_W-1:0] spike_in,
  input  logic               spike_valid,
  output logic [WORD_W-1:0]  word_data,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               word_last,
  output logic [IDX_W-1:0]   word_idx,
  output logic               frame_done,
  output logic               busy,
  output logic               overflow,
  input  logic               ovf_clear,
  output logic [CNT_W-1:0]   frame_count
`ifdef SPIKE_FRAME_POPCOUNT_EN
  ,
  output logic [PC_W-1:0]    spike_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t             state;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] pending;
  logic               pending_full;
  logic [IDX_W-1:0]   idx;

  // Frames are stored zero-padded to a whole number of words, so the
  // tail bits of the final word read as 0 with a plain slice.
  logic [FRAME_W-1:0] spike_pad;
  assign spike_pad = FRAME_W'(spike_in);

  logic accept, last_accept, load_shadow_in, load_from_pend, load_pend, drop;

  always_comb begin
    accept         = 1'b0;
    last_accept    = 1'b0;
    load_shadow_in = 1'b0;
    load_from_pend = 1'b0;
    load_pend      = 1'b0;
    drop           = 1'b0;
    if (state == SEND) begin
      accept      = word_ready;
      last_accept = word_ready && (idx == LAST_IDX);
      if (last_accept) begin
        load_from_pend = pending_full;
        load_shadow_in = !pending_full && spike_valid;
        load_pend      = pending_full && spike_valid;
      end else if (spike_valid) begin
        load_pend = !pending_full;
        drop      = pending_full;
      end
    end else begin
      load_shadow_in = spike_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      pending <= '0;
    end else begin
      if (load_shadow_in)      shadow <= spike_pad;
      else if (load_from_pend) shadow <= pending;
      if (load_pend)           pending <= spike_pad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      pending_full <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      overflow     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (spike_valid) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (accept) begin
            if (!last_accept) begin
              idx <= idx + IDX_W'(1);
            end else begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + CNT_W'(1);
              idx         <= '0;
              if (!pending_full && !spike_valid) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (load_pend)           pending_full <= 1'b1;
      else if (load_from_pend) pending_full <= 1'b0;
      if (drop)                overflow <= 1'b1;
      else if (ovf_clear)      overflow <= 1'b0;
    end
  end

  assign word_valid = (state == SEND);
  assign word_idx   = idx;
  assign word_data  = shadow[idx*WORD_W +: WORD_W];
  assign word_last  = word_valid && (idx == LAST_IDX);
  assign busy       = (state == SEND) || pending_full;

`ifdef SPIKE_FRAME_POPCOUNT_EN
  logic [PC_W-1:0] in_count, shadow_count, pending_count;

  spike_popcount #(.SPIKE_W(SPIKE_W)) u_popcount (
    .bits  (spike_in),
    .count (in_count)
  );

  // Counts travel with their frame through the same load paths as the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_count  <= '0;
      pending_count <= '0;
    end else begin
      if (load_shadow_in)      shadow_count <= in_count;
      else if (load_from_pend) shadow_count <= pending_count;
      if (load_pend)           pending_count <= in_count;
    end
  end

  assign spike_count = shadow_count;
`endif

endmodule
